mux: RTL and testbench
======================

MUX -- requirements
Module: mux

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every data input and output; legal range 1..64.
REQ-002 Port: i_clk  input  1  single clock; all registered state updates on its rising edge.
REQ-003 Port: i_rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: i_a  input  WIDTH  data input 0, selected when i_sel = 0.
REQ-005 Port: i_b  input  WIDTH  data input 1, selected when i_sel = 1.
REQ-006 Port: i_c  input  WIDTH  data input 2, selected when i_sel = 2.
REQ-007 Port: i_d  input  WIDTH  data input 3, selected when i_sel = 3.
REQ-008 Port: i_sel  input  2  select code.
REQ-009 Port: i_en  input  1  capture enable for the registered path.
REQ-010 Port: o_out  output  WIDTH  combinational selected data.
REQ-011 Port: o_out_q  output  WIDTH  registered copy of o_out.
REQ-012 Port: o_sel_q  output  2  registered copy of i_sel, captured with o_out_q.
REQ-013 Port: o_valid_q  output  1  high once o_out_q holds a captured value since reset.

Function
REQ-014 o_out SHALL be purely combinational: i_sel 0/1/2/3 -> i_a/i_b/i_c/i_d, zero clock latency, no dependence on i_clk, i_rst or i_en.
REQ-015 o_out SHALL settle within the same simulation time step as any change on i_a..i_d or i_sel; no latches inferred.
REQ-016 If i_sel contains X or Z, o_out SHALL be all-X; no silent default to a data input.
REQ-017 On a rising i_clk edge with i_rst low and i_en high, o_out_q SHALL load o_out, o_sel_q SHALL load i_sel, o_valid_q SHALL be set to 1.
REQ-018 Rising edge with i_en low: o_out_q, o_sel_q and o_valid_q SHALL hold.
REQ-019 Registered path latency SHALL be exactly one i_clk cycle from the capturing edge.
REQ-020 Data inputs changing in the same cycle as i_sel: the registered value SHALL be the combinational result present at the capturing edge.
REQ-021 All bits are passed unmodified; no sign extension, truncation or arithmetic.
REQ-022 Unconnected i_clk, i_rst and i_en SHALL not affect o_out; the combinational path SHALL be usable standalone.

Reset
REQ-023 While i_rst is high, o_out_q = 0, o_sel_q = 0 and o_valid_q = 0, immediately and independent of i_clk.
REQ-024 Reset asserted mid-operation SHALL clear registered outputs at once; o_out SHALL keep following inputs throughout reset.
REQ-025 First capture after reset SHALL occur on the first rising edge with i_rst low and i_en high.

Verification
REQ-026 i_a=1, i_b=2, i_c=3, i_d=4, WIDTH=8; i_sel = 0,1,2,3, each held 1 ns -> o_out = 1,2,3,4 respectively, checked with case-inequality.
REQ-027 i_sel=2, i_c=8'hA5, i_en=1, one rising edge -> o_out_q=8'hA5, o_sel_q=2, o_valid_q=1 after that edge, not before.
REQ-028 Registered state loaded, i_en=0, change i_sel and data over 3 edges -> o_out_q, o_sel_q unchanged; o_out tracks inputs.
REQ-029 Assert i_rst between clock edges -> o_out_q=0, o_sel_q=0, o_valid_q=0 without a clock edge; o_out unaffected.
REQ-030 i_sel driven to 2'bx -> o_out all-X; restore i_sel=3 -> o_out = i_d.
REQ-031 Bench SHALL print a failure message on any mismatch and "END OF TEST" on completion.

Source files
------------

// File: rtl/mux.sv
// Four-way data selector with a combinational output and an enable-qualified
// registered copy of the selected data, select code and a capture flag.
module mux #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  input  logic [1:0]       i_sel,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] o_out_q,
  output logic [1:0]       o_sel_q,
  output logic             o_valid_q
);

  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d, out_q;
  logic [1:0]       sel_d, sel_q;
  logic             valid_d, valid_q;

  // An unknown select must propagate as all-X rather than pick an input.
  always_comb begin
    out_c = '0;
    case (i_sel)
      2'd0:    out_c = i_a;
      2'd1:    out_c = i_b;
      2'd2:    out_c = i_c;
      2'd3:    out_c = i_d;
      default: out_c = {WIDTH{1'bx}};
    endcase
  end

  assign o_out = out_c;

  // i_en is a one-sided capture qualifier: a high level on a rising edge
  // loads the register set, and there is no backpressure toward the source.
  always_comb begin
    out_d   = out_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (i_en) begin
      out_d   = out_c;
      sel_d   = i_sel;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q   <= '0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign o_out_q   = out_q;
  assign o_sel_q   = sel_q;
  assign o_valid_q = valid_q;

endmodule

// File: tb/tb_mux.sv
// Directed plus randomized checks of the mux against a table-lookup model
// of the selector and a small capture model of the registered outputs.
module tb_mux;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   sel;
  logic         en;
  logic [W-1:0] out, out_q;
  logic [1:0]   sel_q;
  logic         valid_q;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_out;
  logic [1:0]   m_sel;
  logic         m_valid;

  mux #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
    .i_sel(sel), .i_en(en), .o_out(out), .o_out_q(out_q),
    .o_sel_q(sel_q), .o_valid_q(valid_q)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_sel(input logic [1:0] s);
    logic [W-1:0] table_v [4];
    table_v[0] = a;
    table_v[1] = b;
    table_v[2] = c;
    table_v[3] = d;
    return table_v[s];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_q"}, 64'(out_q), 64'(m_out));
    check({tag, ".sel_q"}, 64'(sel_q), 64'(m_sel));
    check({tag, ".valid_q"}, 64'(valid_q), 64'(m_valid));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_out = '0;
    m_sel = 2'd0;
    m_valid = 1'b0;
  endtask

  // One rising edge; the model captures from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst && en) begin
      exp_q.push_back(ref_sel(sel));
      m_out = exp_q.pop_front();
      m_sel = sel;
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic drive(input logic [W-1:0] na, nb, nc, nd, input logic [1:0] ns, input logic ne);
    a = na; b = nb; c = nc; d = nd; sel = ns; en = ne;
  endtask

  initial begin
    logic probe;
    rst = 1'b1;
    drive('0, '0, '0, '0, 2'd0, 1'b0);
    model_reset();
    #1;
    check_regs("reset_hold");

    // Selector table with fixed data values.
    @(negedge clk);
    rst = 1'b0;
    drive(8'd1, 8'd2, 8'd3, 8'd4, 2'd0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("comb_sel%0d", s), 64'(out), 64'(s + 1));
    end

    // Single capture: visible after the edge, not before.
    @(negedge clk);
    drive(8'd1, 8'd2, 8'hA5, 8'd4, 2'd2, 1'b1);
    #1;
    check("pre_edge.out", 64'(out), 64'(8'hA5));
    check_regs("pre_edge");
    tick();
    check_regs("first_capture");
    check("first_capture.lit", 64'(out_q), 64'(8'hA5));

    // Enable low: registers hold while the comb path keeps tracking.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'b0);
      #1;
      check($sformatf("hold_comb%0d", i), 64'(out), 64'(ref_sel(sel)));
      tick();
      check_regs($sformatf("hold%0d", i));
    end

    // Randomized traffic with random enable.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      #1;
      check($sformatf("rand_comb%0d", i), 64'(out), 64'(ref_sel(sel)));
      tick();
      check_regs($sformatf("rand%0d", i));
    end

    // Data and select change late in the cycle; the edge value wins.
    @(negedge clk);
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd0, 1'b1);
    #4;
    drive(8'h5A, 8'hC3, 8'h0F, 8'hF0, 2'd1, 1'b1);
    tick();
    check_regs("late_change");

    // Reset asserted between edges clears registers immediately.
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_regs("async_reset");
    check("async_reset.comb", 64'(out), 64'(ref_sel(sel)));
    sel = 2'd3;
    #1;
    check("reset_comb_track", 64'(out), 64'(8'hF0));
    tick();
    check_regs("reset_over_edge");

    // First enabled edge after release captures.
    @(negedge clk);
    rst = 1'b0;
    drive(8'h01, 8'h80, 8'hFF, 8'h7E, 2'd1, 1'b1);
    tick();
    check_regs("post_reset_capture");

    // Unknown select: only observable on a four-state simulator.
    @(negedge clk);
    en = 1'b0;
    probe = 1'bx;
    sel = 2'bxx;
    #1;
    if ($isunknown(probe))
      check("x_sel", 64'(out), {{(64 - W){1'b0}}, {W{1'bx}}});
    sel = 2'd3;
    #1;
    check("x_restore", 64'(out), 64'(d));

    $display("END OF TEST");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
